fifo_serial_tx: RTL and testbench
=================================

# fifo_serial_tx

Downstream drain stage for the 6-bit synchronous FIFO tile. Watches the FIFO's empty flag, pops one word at a time with a single-cycle read strobe, and shifts it out LSB-first as an asynchronous serial frame (start, 6 data, optional parity, stop) on one pin. This block turns buffered tile data into a UART-style byte stream for off-chip capture.

## Interface
- DATA_W, 6: word width; matches the FIFO data port.
- CLKS_PER_BIT, 4: clock cycles per serial bit; legal range 2..255.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous and active-low, sampled on the rising edge of clk.
- i_enable  in  1  permits starting a new frame; a frame already in progress always completes.
- i_fifo_empty  in  1  FIFO empty flag (FIFO's o_empty).
- i_fifo_dat  in  DATA_W  FIFO read data (FIFO's dat_out), valid the cycle after a read strobe.
- o_fifo_rd_en  out  1  one-cycle pop strobe to the FIFO's rd_en.
- o_tx  out  1  serial line; idles high.
- o_busy  out  1  high from the POP state through the end of the stop bit.

## Operation
- States: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE: o_tx=1, o_busy=0. If i_enable=1 and i_fifo_empty=0, go to POP.
- POP: o_fifo_rd_en=1 for exactly this cycle, then go to LOAD.
- LOAD: capture i_fifo_dat into the shift register, clear the bit counter, then go to START.
- START: o_tx=0 for CLKS_PER_BIT cycles.
- DATA: o_tx = shift[0]; the register shifts right on each bit tick. After DATA_W bits, go to PARITY (if compiled in) or STOP.
- PARITY: o_tx = XOR of the captured word (even parity) for one bit time.
- STOP: o_tx=1 for one bit time. On the final tick, go to POP if i_enable=1 and i_fifo_empty=0; otherwise go to IDLE.
- o_fifo_rd_en is never asserted outside POP. It is never asserted when i_fifo_empty=0 was not sampled in the deciding cycle, so there are no underflow reads.
- The data register and bit counter are never modified mid-frame by FIFO activity. Upstream writes during a frame do not disturb it.

## Timing
- Reset values: o_tx=1, o_fifo_rd_en=0, o_busy=0, state=IDLE, baud counter=0, shift register=0.
- Reset mid-frame: o_tx returns to 1 on the next edge. The word in flight is lost; no extra FIFO pop occurs.
- Latency from IDLE with the FIFO not empty:
  - rd_en is high in cycle n+1, where n is the cycle in which empty=0 is sampled.
  - Data is captured at the end of cycle n+2.
  - The start bit is driven from cycle n+3.
- Frame length: (2+DATA_W)·CLKS_PER_BIT cycles without parity; (3+DATA_W)·CLKS_PER_BIT cycles with parity.
- Back-to-back frames: the line stays high for exactly 2 cycles (POP, LOAD) between the end of stop and the next start.
- Baud counter:
  - Width is ceil(log2(CLKS_PER_BIT)).
  - Counts 0..CLKS_PER_BIT-1 and ticks at the terminal count.
  - Cleared on entry to START so that every bit is exactly CLKS_PER_BIT cycles.
- i_enable falling mid-frame: the frame completes; the block then returns to IDLE.
- i_fifo_empty rising in the same cycle as the stop tick: the block goes to IDLE; the value sampled at the tick decides.

## Configuration
- FIFO_SERIAL_TX_PARITY_EN:
  - Defined: PARITY state present; an even-parity bit sits between data and stop.
  - Undefined: PARITY state and parity logic are absent; DATA goes directly to STOP.

## Structure
- Package fifo_serial_pkg: state enum type, DATA_W default, idle line level constant.
- Sub-module baud_tick_gen (parameter CLKS_PER_BIT; inputs clk, rst_n, clear; output tick).
- All remaining logic (FSM, shift register, bit counter, parity) lives in fifo_serial_tx.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: hold rst_n=0 for 3 cycles with the FIFO not empty -> o_tx=1, rd_en=0, busy=0 throughout; rd_en rises exactly 1 cycle after rst_n goes high.
- Single word: FIFO holds 6'b101101, no parity -> exactly one rd_en pulse. o_tx sequence is 0,1,0,1,1,0,1,1, each bit held 4 cycles (32 cycles total). o_tx then stays 1 and busy=0.
- Parity: with FIFO_SERIAL_TX_PARITY_EN defined, words 6'b101101 and 6'b000111 -> parity bits 0 and 1; frames are 36 cycles each.
- Back-to-back: 3 words queued -> 3 rd_en pulses; exactly 2 high cycles between each stop and the next start; data order is preserved.
- Enable gating: i_enable=0 while the FIFO is not empty -> no rd_en. Drop i_enable in the middle of the DATA state -> the current frame completes, and no further pop occurs.
- Mid-frame reset: assert rst_n=0 during bit 3 -> o_tx=1 on the next edge. After release, the next queued word is sent intact; the total rd_en count equals the number of frames started.

Source files
------------

// File: rtl/fifo_serial_pkg.sv
// fifo_serial_pkg: shared types and constants for the FIFO serial drain stage.
// Contents: frame FSM state enum, default word width, idle line level.
package fifo_serial_pkg;

  localparam int unsigned DATA_W_DEF = 6;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

endpackage

// File: rtl/fifo_serial_tx_baud_tick_gen.sv
// baud_tick_gen: bit-time divider. Counts 0..CLKS_PER_BIT-1 and flags the
// terminal count; 'clear' holds the count at zero so each frame starts aligned.
// Ports: clk, rst_n (sync, active-low), clear (hold at zero), tick (terminal count).
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned     CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Free-running bit-time counter, wraps at the terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt_q <= '0;
    end else if (cnt_q == TERM) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = (cnt_q == TERM) && !clear;

endmodule

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops 6-bit words from a synchronous FIFO and sends each one
// LSB-first as start / data / [even parity] / stop on a single serial pin.
// Optional feature macro: FIFO_SERIAL_TX_PARITY_EN (adds the parity bit).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_enable          allows a new frame to start
//   i_fifo_empty      FIFO empty flag
//   i_fifo_dat        FIFO read data, valid the cycle after o_fifo_rd_en
//   o_fifo_rd_en      single-cycle pop strobe
//   o_tx              serial line, idles high
//   o_busy            high from POP through the end of the stop bit
module fifo_serial_tx
  import fifo_serial_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_dat,
  output logic              o_fifo_rd_en,
  output logic              o_tx,
  output logic              o_busy
);

  localparam int unsigned BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  state_t               state, state_next;
  logic [DATA_W-1:0]    shift_q, shift_next;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_next;
  logic                 tick, baud_clear, can_pop;
  logic                 tx_d, rd_en_d, busy_d;

  assign can_pop    = i_enable && !i_fifo_empty;
  // Divider runs only while a bit is on the line; entering START finds it at zero.
  assign baud_clear = (state == IDLE) || (state == POP) || (state == LOAD);

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (baud_clear),
    .tick  (tick)
  );

`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic par_q;

  // Even parity of the word, taken as it is loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (state == LOAD) begin
      par_q <= ^i_fifo_dat;
    end
  end
`endif

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      o_tx         <= IDLE_LEVEL;
      o_fifo_rd_en <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state        <= state_next;
      shift_q      <= shift_next;
      bit_cnt_q    <= bit_cnt_next;
      o_tx         <= tx_d;
      o_fifo_rd_en <= rd_en_d;
      o_busy       <= busy_d;
    end
  end

  // Next state and datapath updates.
  always_comb begin
    state_next   = state;
    shift_next   = shift_q;
    bit_cnt_next = bit_cnt_q;
    case (state)
      IDLE:  if (can_pop) state_next = POP;
      POP:   state_next = LOAD;
      LOAD: begin
        shift_next   = i_fifo_dat;
        bit_cnt_next = '0;
        state_next   = START;
      end
      START: if (tick) state_next = DATA;
      DATA: begin
        if (tick) begin
          shift_next   = shift_q >> 1;
          bit_cnt_next = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY: if (tick) state_next = STOP;
`endif
      STOP:  if (tick) state_next = can_pop ? POP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output values for the upcoming cycle, registered above.
  always_comb begin
    tx_d    = IDLE_LEVEL;
    rd_en_d = 1'b0;
    busy_d  = 1'b1;
    case (state_next)
      IDLE:   busy_d  = 1'b0;
      POP:    rd_en_d = 1'b1;
      START:  tx_d    = 1'b0;
      DATA:   tx_d    = shift_next[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY: tx_d    = par_q;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx: self-checking bench for fifo_serial_tx with a behavioural
// FIFO and a frame-level reference of the expected serial line.
module tb_fifo_serial_tx;

  localparam int unsigned DATA_W = 6;
  localparam int unsigned C      = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NBITS = 2 + DATA_W + (PAR ? 1 : 0);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_enable;
  logic              i_fifo_empty;
  logic [DATA_W-1:0] i_fifo_dat;
  logic              o_fifo_rd_en;
  logic              o_tx;
  logic              o_busy;

  int asserts = 0;
  int errors  = 0;

  // Behavioural FIFO: one-cycle read latency.
  logic [DATA_W-1:0] fifo_mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;
  int underflow = 0;
  logic [DATA_W-1:0] exp_q[$];

  assign i_fifo_empty = (wr_ptr == rd_ptr);

  always #5 clk = ~clk;

  fifo_serial_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (i_enable),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_dat   (i_fifo_dat),
    .o_fifo_rd_en (o_fifo_rd_en),
    .o_tx         (o_tx),
    .o_busy       (o_busy)
  );

  always @(posedge clk) begin
    if (o_fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (wr_ptr == rd_ptr) begin
        underflow <= underflow + 1;
      end else begin
        i_fifo_dat <= fifo_mem[rd_ptr % 64];
        rd_ptr     <= rd_ptr + 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [DATA_W-1:0] w);
    fifo_mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
  endtask

  function automatic logic exp_bit(input logic [DATA_W-1:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= DATA_W) return w[b-1];
    if (PAR && b == DATA_W + 1) return ^w;
    return 1'b1;
  endfunction

  // Waits (bounded) for the start bit; returns at the negedge where o_tx is 0.
  task automatic wait_start(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      asserts++;
      errors++;
      $display("FAIL %s_start: no start bit within 200 cycles, o_tx=%b required 0", name, o_tx);
    end
  endtask

  // Checks a whole frame cycle by cycle against the next expected word.
  // Entry: negedge of the first start cycle. Exit: negedge of the last stop cycle.
  task automatic check_frame(input string name, input int drop_bit);
    logic [DATA_W-1:0] w;
    logic e, bad, seen;
    if (exp_q.size() == 0) begin
      asserts++;
      errors++;
      $display("FAIL %s_model: no expected word, actual=empty required=word", name);
      return;
    end
    w = exp_q.pop_front();
    for (int b = 0; b < NBITS; b++) begin
      e = exp_bit(w, b);
      bad = 1'b0;
      seen = e;
      for (int c = 0; c < int'(C); c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (b == drop_bit && c == 0) i_enable = 1'b0;
        if (o_tx !== e && !bad) begin
          bad  = 1'b1;
          seen = o_tx;
        end
      end
      asserts++;
      if (bad) begin
        errors++;
        $display("FAIL %s_bit%0d: word=%b o_tx=%b required %b", name, b, w, seen, e);
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst_n    = 1'b0;
    i_enable = 1'b1;
    push_word(6'b110010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      asserts++;
      if (o_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: o_tx=%b required 1", o_tx); end
      asserts++;
      if (o_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: rd_en=%b required 0", o_fifo_rd_en); end
      asserts++;
      if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b required 0", o_busy); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    asserts++;
    if (o_fifo_rd_en !== 1'b1) begin errors++; $display("FAIL reset_release_rd_en: rd_en=%b required 1", o_fifo_rd_en); end
    wait_start("reset", ok);
    if (ok) check_frame("reset", -1);
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    int rd0;
    rd0 = rd_cnt;
    push_word(6'b101101);
    @(negedge clk);
    asserts++;
    if (o_fifo_rd_en !== 1'b1) begin errors++; $display("FAIL single_pop_latency: rd_en=%b required 1", o_fifo_rd_en); end
    @(negedge clk);
    asserts++;
    if (o_fifo_rd_en !== 1'b0 || o_tx !== 1'b1) begin
      errors++;
      $display("FAIL single_load_cycle: rd_en=%b tx=%b required rd_en=0 tx=1", o_fifo_rd_en, o_tx);
    end
    @(negedge clk);
    asserts++;
    if (o_tx !== 1'b0) begin errors++; $display("FAIL single_start_latency: o_tx=%b required 0", o_tx); end
    ok = (o_tx === 1'b0);
    if (!ok) wait_start("single", ok);
    if (ok) check_frame("single", -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      asserts++;
      if (o_tx !== 1'b1 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL single_idle: tx=%b busy=%b required tx=1 busy=0", o_tx, o_busy);
      end
    end
    asserts++;
    if (rd_cnt - rd0 != 1) begin errors++; $display("FAIL single_pop_count: pops=%0d required 1", rd_cnt - rd0); end
  endtask

`ifdef FIFO_SERIAL_TX_PARITY_EN
  task automatic test_parity();
    bit ok;
    push_word(6'b101101);
    push_word(6'b000111);
    wait_start("parity0", ok);
    if (ok) check_frame("parity0", -1);
    wait_start("parity1", ok);
    if (ok) check_frame("parity1", -1);
    @(negedge clk);
  endtask
`endif

  task automatic test_back_to_back();
    bit ok;
    int rd0;
    logic t1, t2, t3;
    rd0 = rd_cnt;
    for (int i = 0; i < 3; i++) push_word(DATA_W'($urandom));
    wait_start("b2b", ok);
    for (int k = 0; k < 3 && ok; k++) begin
      check_frame($sformatf("b2b_w%0d", k), -1);
      if (k < 2) begin
        @(negedge clk); t1 = o_tx;
        @(negedge clk); t2 = o_tx;
        @(negedge clk); t3 = o_tx;
        asserts++;
        if (!(t1 === 1'b1 && t2 === 1'b1 && t3 === 1'b0)) begin
          errors++;
          ok = 1'b0;
          $display("FAIL b2b_gap%0d: tx after stop=%b%b%b required 110", k, t1, t2, t3);
        end
      end
    end
    repeat (3) @(negedge clk);
    asserts++;
    if (rd_cnt - rd0 != 3) begin errors++; $display("FAIL b2b_pop_count: pops=%0d required 3", rd_cnt - rd0); end
  endtask

  task automatic test_enable();
    bit ok;
    int rd0;
    rd0 = rd_cnt;
    i_enable = 1'b0;
    push_word(DATA_W'($urandom));
    push_word(DATA_W'($urandom));
    repeat (20) @(negedge clk);
    asserts++;
    if (rd_cnt != rd0 || o_tx !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL enable_gate: pops=%0d tx=%b busy=%b required 0/1/0", rd_cnt - rd0, o_tx, o_busy);
    end
    i_enable = 1'b1;
    wait_start("enable", ok);
    if (ok) check_frame("enable_drop", 3);
    repeat (20) @(negedge clk);
    asserts++;
    if (rd_cnt - rd0 != 1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL enable_drop_stop: pops=%0d busy=%b required 1/0", rd_cnt - rd0, o_busy);
    end
    i_enable = 1'b1;
    wait_start("enable_resume", ok);
    if (ok) check_frame("enable_resume", -1);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_midframe_reset();
    bit ok;
    int rd0;
    rd0 = rd_cnt;
    push_word(DATA_W'($urandom));
    push_word(DATA_W'($urandom));
    wait_start("mrst", ok);
    if (ok) begin
      repeat (4 * C) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      asserts++;
      if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_fifo_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL mrst_line: tx=%b busy=%b rd_en=%b required 1/0/0", o_tx, o_busy, o_fifo_rd_en);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      void'(exp_q.pop_front());
      wait_start("mrst_next", ok);
      if (ok) check_frame("mrst_next", -1);
    end
    repeat (3) @(negedge clk);
    asserts++;
    if (rd_cnt - rd0 != 2) begin errors++; $display("FAIL mrst_pop_count: pops=%0d required 2", rd_cnt - rd0); end
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef FIFO_SERIAL_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_enable();
    test_midframe_reset();
    asserts++;
    if (underflow != 0) begin errors++; $display("FAIL underflow: reads on empty=%0d required 0", underflow); end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

endmodule
